// File: rtl/insn_fetch_if.sv
// Fetch-controller bus bundle: instruction-memory read port plus decoder-facing
// instruction handshake.
interface insn_fetch_if #(
  parameter int LEN_INSN = 32,
  parameter int LEN_ADDR = 16
);
  logic                mem_req;
  logic [LEN_ADDR-1:0] mem_addr;
  logic                mem_ack;
  logic [LEN_INSN-1:0] mem_rdata;
  logic [LEN_INSN-1:0] insn_o;
  logic [LEN_ADDR-1:0] pc_o;
  logic                insn_valid;
  logic                insn_ready;

  modport master (
    output mem_req, mem_addr, insn_o, pc_o, insn_valid,
    input  mem_ack, mem_rdata, insn_ready
  );

  modport slave (
    input  mem_req, mem_addr, insn_o, pc_o, insn_valid,
    output mem_ack, mem_rdata, insn_ready
  );
endinterface

// File: rtl/insn_fetch_ctrl.sv
// Single-outstanding instruction fetch controller: IDLE/FETCH/VALID FSM with
// redirect handling that lets an un-acked request finish before retargeting.
module insn_fetch_ctrl #(
  parameter int                  LEN_INSN = 32,
  parameter int                  LEN_ADDR = 16,
  parameter logic [LEN_ADDR-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                redirect,
  input  logic [LEN_ADDR-1:0] redirect_pc,
  output logic [15:0]         fetch_count,
  insn_fetch_if.master        bus
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t              state, state_n;
  logic [LEN_ADDR-1:0] pc, pc_n;
  logic [LEN_ADDR-1:0] kaddr, kaddr_n;
  logic                kill, kill_n;
  logic [LEN_INSN-1:0] insn_q, insn_n;
  logic [LEN_ADDR-1:0] pc_q, pco_n;
  logic [15:0]         cnt, cnt_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      kaddr  <= RESET_PC;
      kill   <= 1'b0;
      insn_q <= '0;
      pc_q   <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      kaddr  <= kaddr_n;
      kill   <= kill_n;
      insn_q <= insn_n;
      pc_q   <= pco_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    kaddr_n = kaddr;
    kill_n  = kill;
    insn_n  = insn_q;
    pco_n   = pc_q;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (redirect) pc_n = redirect_pc;
        if (run) state_n = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          pc_n = redirect_pc;
          if (bus.mem_ack) begin
            kill_n  = 1'b0;
            state_n = run ? FETCH : IDLE;
          end else if (!kill) begin
            // park the in-flight address so the bus stays stable until the ack
            kill_n  = 1'b1;
            kaddr_n = pc;
          end
        end else if (bus.mem_ack) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = run ? FETCH : IDLE;
          end else begin
            insn_n  = bus.mem_rdata;
            pco_n   = pc;
            pc_n    = pc + LEN_ADDR'(1);
            state_n = VALID;
          end
        end
      end
      VALID: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = run ? FETCH : IDLE;
        end else if (bus.insn_ready) begin
          cnt_n   = cnt + 16'd1;
          state_n = run ? FETCH : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.mem_req    = (state == FETCH);
  assign bus.mem_addr   = kill ? kaddr : pc;
  assign bus.insn_valid = (state == VALID);
  assign bus.insn_o     = insn_q;
  assign bus.pc_o       = pc_q;
  assign fetch_count    = cnt;

endmodule

// File: tb/tb_insn_fetch_ctrl.sv
// Directed bench for insn_fetch_ctrl; memory returns addr+0x100, scoreboards
// check every memory handshake address and every consumed instruction.
module tb_insn_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] mq[$];
  logic [47:0] iq[$];

  insn_fetch_if #(.LEN_INSN(32), .LEN_ADDR(16)) bus ();

  insn_fetch_ctrl #(.LEN_INSN(32), .LEN_ADDR(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_count (fetch_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = 32'(bus.mem_addr) + 32'h100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_insn(input logic [15:0] a);
    iq.push_back({a, 32'(a) + 32'h100});
  endtask

  // monitor: compares handshakes against the queued expectations
  always @(negedge clk) begin
    logic [47:0] e;
    if (rst) begin
      if (bus.mem_req && bus.mem_ack) begin
        if (mq.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexp: got addr %0h expected no request", bus.mem_addr);
        end else chk("mem_addr_sb", 32'(bus.mem_addr), 32'(mq.pop_front()));
      end
      if (bus.insn_valid && bus.insn_ready && !redirect) begin
        if (iq.size() == 0) begin
          total++; bad++;
          $display("FAIL insn_unexp: got pc %0h expected no consume", bus.pc_o);
        end else begin
          e = iq.pop_front();
          chk("pc_o_sb", 32'(bus.pc_o), 32'(e[47:32]));
          chk("insn_o_sb", bus.insn_o, e[31:0]);
        end
      end
    end
  end

  task automatic chk_idle(input string name);
    chk({name, "_req"}, 32'(bus.mem_req), 32'd0);
    chk({name, "_valid"}, 32'(bus.insn_valid), 32'd0);
    chk({name, "_insn"}, bus.insn_o, 32'd0);
    chk({name, "_pc_o"}, 32'(bus.pc_o), 32'd0);
    chk({name, "_cnt"}, 32'(fetch_count), 32'd0);
    chk({name, "_addr"}, 32'(bus.mem_addr), 32'd0);
  endtask

  initial begin
    rst = 1'b0; run = 1'b1; redirect = 1'b0; redirect_pc = '0;
    bus.mem_ack = 1'b1; bus.insn_ready = 1'b1;
    #2;
    chk_idle("reset");
    step(); step();

    // streaming: addr 0,1,2, valid every other cycle
    mq.push_back(16'h0); mq.push_back(16'h1); mq.push_back(16'h2);
    exp_insn(16'h0); exp_insn(16'h1); exp_insn(16'h2);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stream_valid", 32'(bus.insn_valid), 32'(i % 2));
      chk("stream_req", 32'(bus.mem_req), 32'((i + 1) % 2));
    end
    run = 1'b0;
    step();
    chk("stream_cnt", 32'(fetch_count), 32'd3);
    chk("stream_stop_req", 32'(bus.mem_req), 32'd0);

    // delayed ack at addr 5
    bus.mem_ack = 1'b0; bus.insn_ready = 1'b0; run = 1'b1;
    redirect = 1'b1; redirect_pc = 16'h0005;
    step();
    redirect = 1'b0;
    mq.push_back(16'h5); exp_insn(16'h5);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ack = 1'b1;
      chk("wait_req", 32'(bus.mem_req), 32'd1);
      chk("wait_addr", 32'(bus.mem_addr), 32'h5);
      chk("wait_insn_hold", bus.insn_o, 32'h102);
      if (i < 3) step();
    end
    step();

    // backpressure: hold 4 cycles
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", 32'(bus.insn_valid), 32'd1);
      chk("hold_insn", bus.insn_o, 32'h105);
      chk("hold_pc", 32'(bus.pc_o), 32'h5);
      chk("hold_req", 32'(bus.mem_req), 32'd0);
      chk("hold_cnt", 32'(fetch_count), 32'd3);
      step();
    end
    bus.insn_ready = 1'b1;
    mq.push_back(16'h6); exp_insn(16'h6);
    step();
    step();
    bus.mem_ack = 1'b0;
    step();
    chk("pre_kill_addr", 32'(bus.mem_addr), 32'h7);
    chk("pre_kill_cnt", 32'(fetch_count), 32'd5);

    // redirect to 0x40 while fetch at 0x07 is un-acked
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("kill_req", 32'(bus.mem_req), 32'd1);
      chk("kill_addr", 32'(bus.mem_addr), 32'h7);
      chk("kill_valid", 32'(bus.insn_valid), 32'd0);
      if (i == 0) step();
    end
    mq.push_back(16'h7); bus.mem_ack = 1'b1;
    step();
    chk("killed_valid", 32'(bus.insn_valid), 32'd0);
    chk("retarget_addr", 32'(bus.mem_addr), 32'h40);
    chk("retarget_req", 32'(bus.mem_req), 32'd1);
    mq.push_back(16'h40); exp_insn(16'h40);
    step();
    chk("retarget_pc_o", 32'(bus.pc_o), 32'h40);
    mq.push_back(16'h41);
    step();
    step();

    // redirect + ready together in VALID, then wrap at 0xFFFF
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    chk("redir_cnt", 32'(fetch_count), 32'd6);
    chk("redir_valid", 32'(bus.insn_valid), 32'd0);
    chk("redir_addr", 32'(bus.mem_addr), 32'hFFFF);
    mq.push_back(16'hFFFF); exp_insn(16'hFFFF);
    step();
    chk("wrap_insn", bus.insn_o, 32'h100FF);
    bus.mem_ack = 1'b0;
    step();
    chk("wrap_addr", 32'(bus.mem_addr), 32'h0);
    chk("wrap_req", 32'(bus.mem_req), 32'd1);
    chk("wrap_cnt", 32'(fetch_count), 32'd7);

    // async reset mid-request
    #2; rst = 1'b0; run = 1'b0;
    #1;
    chk("rst_req_drop", 32'(bus.mem_req), 32'd0);
    step(); step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("post_rst");
    end
    chk("mem_sb_empty", 32'(mq.size()), 32'd0);
    chk("insn_sb_empty", 32'(iq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/insn_fetch_ctrl.md
INSN_FETCH_CTRL -- requirements
Module: insn_fetch_ctrl

Interface
REQ-001: Parameter LEN_INSN, default 32, instruction word width.
REQ-002: Parameter LEN_ADDR, default 16, instruction memory word-address width.
REQ-003: Parameter RESET_PC, default 0, fetch address after reset.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: rst  input  1  asynchronous, active-low reset.
REQ-006: run  input  1  1 = fetching permitted; 0 = stop after the in-flight request.
REQ-007: mem_req  output  1  instruction memory read request.
REQ-008: mem_addr  output  LEN_ADDR  read word address; valid while mem_req=1.
REQ-009: mem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-010: mem_rdata  input  LEN_INSN  read data; sampled only when mem_req=1 and mem_ack=1.
REQ-011: insn_o  output  LEN_INSN  captured instruction; drives the decoder's insn input.
REQ-012: pc_o  output  LEN_ADDR  address of the word currently in insn_o.
REQ-013: insn_valid  output  1  insn_o/pc_o hold an unconsumed instruction.
REQ-014: insn_ready  input  1  downstream consumes insn_o when insn_valid=1 and insn_ready=1.
REQ-015: redirect  input  1  one-cycle pulse; replaces the fetch PC.
REQ-016: redirect_pc  input  LEN_ADDR  new fetch address; sampled when redirect=1.
REQ-017: fetch_count  output  16  count of instructions consumed downstream.

Function
REQ-018: The FSM SHALL have exactly three states: IDLE, FETCH and VALID.
REQ-019: In IDLE, mem_req=0 and insn_valid=0; if run=1, the next state is FETCH.
REQ-020: In FETCH, mem_req=1 and mem_addr=pc; mem_req and mem_addr stay stable until mem_ack=1.
REQ-021: FETCH with mem_ack=1 and kill=0 SHALL capture insn_o<=mem_rdata and pc_o<=pc, set pc<=pc+1, and move to VALID.
REQ-022: pc increment wraps modulo 2^LEN_ADDR (all-ones -> 0).
REQ-023: In VALID, insn_valid=1 and mem_req=0; insn_o and pc_o stay stable until consumed.
REQ-024: A VALID-state consume (insn_ready=1) SHALL increment fetch_count, wrapping 0xFFFF -> 0.
REQ-025: After a consume, the next state is FETCH if run=1, otherwise IDLE.
REQ-026: Fetch-to-valid latency is one cycle after the ack, and each instruction has a one-cycle bubble.
REQ-027: run=0 during FETCH SHALL NOT abort the request; the request completes normally per REQ-021.
REQ-028: redirect has priority over all other events.
REQ-029: redirect SHALL set pc<=redirect_pc.
REQ-030: redirect SHALL drop insn_valid next cycle; the held instruction is discarded and not counted.
REQ-031: redirect in IDLE or VALID SHALL move the FSM to FETCH if run=1, otherwise to IDLE.
REQ-032: redirect in FETCH with mem_ack=1 in the same cycle SHALL discard mem_rdata; the next state is FETCH (run=1) or IDLE.
REQ-033: redirect in FETCH without mem_ack SHALL set kill=1 and remain in FETCH on the old address.
REQ-034: On the ack of a killed request, the data is discarded, kill is cleared, and the FSM re-enters FETCH at redirect_pc (or IDLE if run=0).
REQ-035: A redirect while kill=1 SHALL only update pc; kill stays 1.
REQ-036: redirect and insn_ready in the same VALID cycle: the redirect wins, and no consume or count occurs.

Reset
REQ-037: rst=0 SHALL asynchronously force: state=IDLE, pc=RESET_PC, kill=0, mem_req=0, insn_valid=0, insn_o=0, pc_o=0, fetch_count=0.
REQ-038: Reset asserted mid-request SHALL drop mem_req immediately; after release, fetching restarts at RESET_PC only when run=1.

Verification
REQ-039: Bench scenario: reset, run=1, mem_ack=1 always, insn_ready=1, rdata=addr+0x100 -> mem_addr sequence 0,1,2; insn_o 0x100,0x101,0x102 each valid 1 cycle every 2 cycles; fetch_count=3.
REQ-040: Bench scenario: mem_ack delayed 3 cycles at addr 5 -> mem_req/mem_addr=5 stable for 4 cycles; insn_o captured only on the ack.
REQ-041: Bench scenario: insn_valid with insn_ready=0 for 4 cycles -> insn_o and pc_o unchanged, no new mem_req, fetch_count unchanged.
REQ-042: Bench scenario: redirect to 0x40 while FETCH at 0x07 is unacked -> request at 0x07 completes, data discarded, insn_valid stays 0, next mem_addr=0x40, pc_o=0x40 on the following valid.
REQ-043: Bench scenario: pc=0xFFFF fetched -> next mem_addr=0x0000; redirect and insn_ready together in VALID -> no count, next fetch at redirect_pc.
REQ-044: Bench scenario: rst pulled low during FETCH -> mem_req=0 within the same cycle; with run=0 after release, the FSM remains in IDLE with all outputs at reset values.
